// File: rtl/mmio_fabric_pkg.sv
// Shared types and constants for the MMIO fabric.
// FSM states, error codes and status-register bit layout.
package mmio_fabric_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        LOCAL,
        ERR,
        RESP
    } state_t;

    localparam logic [7:0] ERR_SLAVE_MISS = 8'hFF;

    localparam int ST_CNT_LSB  = 16;
    localparam int ST_IDX_LSB  = 8;
    localparam int ST_TO_BIT   = 1;
    localparam int ST_MISS_BIT = 0;

    function automatic logic [31:0] status_word(
        input logic [15:0] cnt,
        input logic [7:0]  idx,
        input logic        to,
        input logic        miss
    );
        logic [31:0] w;
        w = '0;
        w[ST_CNT_LSB +: 16] = cnt;
        w[ST_IDX_LSB +: 8]  = idx;
        w[ST_TO_BIT]        = to;
        w[ST_MISS_BIT]      = miss;
        return w;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Address decoder: base/mask match per slave, lowest index wins.
// Also flags hits on the local status/error-address words.
module mmio_addr_decode
    import mmio_fabric_pkg::*;
#(
    parameter int                         NUM_SLAVES  = 4,
    parameter int                         IW          = 2,
    parameter logic [NUM_SLAVES*32-1:0]   ADDR_BASE   = '0,
    parameter logic [NUM_SLAVES*32-1:0]   ADDR_MASK   = '0,
    parameter logic [31:0]                STATUS_ADDR = 32'h0300_0000
) (
    input  logic [31:0]   addr,
    output logic          hit,
    output logic [IW-1:0] idx,
    output logic          status_hit
);

    localparam logic [31:0] ERRA_ADDR = STATUS_ADDR + 32'd4;

    always_comb begin
        hit        = 1'b0;
        idx        = '0;
        status_hit = (addr[31:2] == STATUS_ADDR[31:2]) ||
                     (addr[31:2] == ERRA_ADDR[31:2]);
        // Scan downward so the lowest matching index is the last written.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & ADDR_MASK[i*32 +: 32]) == ADDR_BASE[i*32 +: 32]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_fabric.sv
// Single-outstanding MMIO fabric between the CPU mem port and slaves.
// Adds decode-miss / timeout error responses and a status register.
module mmio_fabric
    import mmio_fabric_pkg::*;
#(
    parameter int                         NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0]   ADDR_BASE      = '0,
    parameter logic [NUM_SLAVES*32-1:0]   ADDR_MASK      = '0,
    parameter int                         TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF,
    parameter logic [31:0]                STATUS_ADDR    = 32'h0300_0000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    output logic                     err_irq
);

    localparam int          IW        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [31:0] ERRA_ADDR = STATUS_ADDR + 32'd4;
    localparam logic [15:0] TMO       = 16'(TIMEOUT_CYCLES);

    state_t          state, state_n;
    logic [IW-1:0]   sel;
    logic [15:0]     cnt;
    logic            cause_to;
    logic [15:0]     err_count;
    logic [7:0]      err_idx;
    logic            flag_to;
    logic            flag_miss;
    logic [31:0]     err_addr;

    logic            dec_hit;
    logic [IW-1:0]   dec_idx;
    logic            dec_status;
    logic            ready_sel;
    logic            timeout;
    logic            is_erra;

    mmio_addr_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .IW          (IW),
        .ADDR_BASE   (ADDR_BASE),
        .ADDR_MASK   (ADDR_MASK),
        .STATUS_ADDR (STATUS_ADDR)
    ) u_decode (
        .addr        (mem_addr),
        .hit         (dec_hit),
        .idx         (dec_idx),
        .status_hit  (dec_status)
    );

    assign ready_sel = s_ready[sel];
    assign timeout   = (cnt >= TMO);
    assign is_erra   = (s_addr[31:2] == ERRA_ADDR[31:2]);
    assign mem_ready = (state == RESP);
    assign err_irq   = flag_to | flag_miss;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (dec_status)   state_n = LOCAL;
                    else if (dec_hit) state_n = ACTIVE;
                    else              state_n = ERR;
                end
            end
            // Completion beats a coincident timeout.
            ACTIVE: begin
                if (ready_sel)    state_n = RESP;
                else if (timeout) state_n = ERR;
            end
            LOCAL:   state_n = RESP;
            ERR:     state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            sel       <= '0;
            cnt       <= '0;
            cause_to  <= 1'b0;
            s_valid   <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
            mem_rdata <= '0;
            err_count <= '0;
            err_idx   <= '0;
            flag_to   <= 1'b0;
            flag_miss <= 1'b0;
            err_addr  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (mem_valid) begin
                        s_addr   <= mem_addr;
                        s_wdata  <= mem_wdata;
                        s_wstrb  <= mem_wstrb;
                        sel      <= dec_idx;
                        cnt      <= 16'd1;
                        cause_to <= 1'b0;
                        if (!dec_status && dec_hit)
                            s_valid <= NUM_SLAVES'(1) << dec_idx;
                    end
                end
                ACTIVE: begin
                    if (ready_sel) begin
                        mem_rdata <= s_rdata[sel*32 +: 32];
                        s_valid   <= '0;
                    end else if (timeout) begin
                        s_valid  <= '0;
                        cause_to <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LOCAL: begin
                    if (s_wstrb != 4'd0) begin
                        mem_rdata <= '0;
                        if (!is_erra) begin
                            err_count <= '0;
                            err_idx   <= '0;
                            flag_to   <= 1'b0;
                            flag_miss <= 1'b0;
                            err_addr  <= '0;
                        end
                    end else if (is_erra) begin
                        mem_rdata <= err_addr;
                    end else begin
                        mem_rdata <= status_word(err_count, err_idx,
                                                 flag_to, flag_miss);
                    end
                end
                ERR: begin
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                    err_addr  <= s_addr;
                    mem_rdata <= ERR_RDATA;
                    if (cause_to) begin
                        flag_to <= 1'b1;
                        err_idx <= 8'(sel);
                    end else begin
                        flag_miss <= 1'b1;
                        err_idx   <= ERR_SLAVE_MISS;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed vector bench for mmio_fabric: slave access, overlap,
// decode miss, timeout race, status clear and mid-transaction reset.
module tb_mmio_fabric;

    localparam int NS = 4;

    localparam logic [NS*32-1:0] BASE = {32'h0400_0000, 32'h0200_0000,
                                         32'h0200_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFF00_0000, 32'hFFFF_0000,
                                         32'hFF00_0000, 32'hFFFE_0000};

    logic            clk = 1'b0;
    logic            resetn;
    logic            mem_valid;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic [NS-1:0]   s_valid;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [NS-1:0]   s_ready;
    logic [NS*32-1:0] s_rdata;
    logic            err_irq;

    int checks = 0;
    int errors = 0;

    mmio_fabric #(
        .NUM_SLAVES     (NS),
        .ADDR_BASE      (BASE),
        .ADDR_MASK      (MASK),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF),
        .STATUS_ADDR    (32'h0300_0000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_irq   (err_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy_k;
        logic [3:0]  rdy_mask;
        logic [3:0]  exp_sv;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_cyc;
        logic        exp_irq;
    } vec_t;

    vec_t v[20];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Entered at #1 into an IDLE cycle (cycle 0); leaves in the next IDLE.
    task automatic run_txn(input vec_t t, output int cyc,
                           output logic [31:0] rd, output logic [3:0] sv,
                           output logic [31:0] sa);
        cyc = -1;
        rd  = '0;
        sv  = '0;
        sa  = '0;
        mem_addr  = t.addr;
        mem_wdata = t.wdata;
        mem_wstrb = t.wstrb;
        mem_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                sv = s_valid;
                sa = s_addr;
            end
            if (mem_ready) begin
                cyc = c;
                rd  = mem_rdata;
                break;
            end
            s_ready = (c == t.rdy_k) ? t.rdy_mask : '0;
        end
        mem_valid = 1'b0;
        s_ready   = '0;
        @(posedge clk);
        #1;
        if (cyc > 0)
            check("ready_pulse", {31'd0, mem_ready}, 32'd0);
    endtask

    task automatic apply(input string tag, input vec_t t);
        int          cyc;
        logic [31:0] rd;
        logic [3:0]  sv;
        logic [31:0] sa;
        run_txn(t, cyc, rd, sv, sa);
        check({tag, " cyc"}, 32'(cyc), 32'(t.exp_cyc));
        check({tag, " s_valid"}, {28'd0, sv}, {28'd0, t.exp_sv});
        if (t.exp_sv != 4'd0)
            check({tag, " s_addr"}, sa, t.addr);
        if (t.chk_rd)
            check({tag, " rdata"}, rd, t.exp_rd);
        check({tag, " irq"}, {31'd0, err_irq}, {31'd0, t.exp_irq});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv;
        //       addr           wdata  wstrb k  rmask   sv    chk rdata         cyc irq
        v[0]  = '{32'h0000_0100, 0, 4'h0, 2, 4'b0001, 4'b0001, 1, 32'h0000_AAAA, 3, 0};
        v[1]  = '{32'h0000_0104, 0, 4'h0, 1, 4'b0001, 4'b0001, 1, 32'h0000_AAAA, 2, 0};
        v[2]  = '{32'h0200_0004, 32'h55, 4'hF, 3, 4'b0010, 4'b0010, 0, 0, 4, 0};
        v[3]  = '{32'h0400_0010, 0, 4'h0, 1, 4'b1000, 4'b1000, 1, 32'h3333_3333, 2, 0};
        v[4]  = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0000_0000, 2, 0};
        v[5]  = '{32'h0500_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'hDEAD_BEEF, 2, 1};
        v[6]  = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0001_FF01, 2, 1};
        v[7]  = '{32'h0300_0004, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0500_0000, 2, 1};
        v[8]  = '{32'h0400_0000, 0, 4'h0, 0, 4'b0000, 4'b1000, 1, 32'hDEAD_BEEF, 10, 1};
        v[9]  = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0002_0303, 2, 1};
        v[10] = '{32'h0300_0004, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0400_0000, 2, 1};
        v[11] = '{32'h0400_0008, 0, 4'h0, 8, 4'b1000, 4'b1000, 1, 32'h3333_3333, 9, 1};
        v[12] = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0002_0303, 2, 1};
        v[13] = '{32'h0300_0004, 32'hFFFF_FFFF, 4'hF, 0, 4'b0000, 4'b0000, 0, 0, 2, 1};
        v[14] = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0002_0303, 2, 1};
        v[15] = '{32'h0600_0000, 32'h1, 4'hF, 0, 4'b0000, 4'b0000, 1, 32'hDEAD_BEEF, 2, 1};
        v[16] = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0003_FF03, 2, 1};
        v[17] = '{32'h0300_0000, 32'h1, 4'h1, 0, 4'b0000, 4'b0000, 0, 0, 2, 0};
        v[18] = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0000_0000, 2, 0};
        v[19] = '{32'h0300_0004, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0000_0000, 2, 0};

        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        s_ready   = '0;
        s_rdata   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_AAAA};

        repeat (3) @(posedge clk);
        #1;
        check("rst mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst mem_rdata", mem_rdata, 32'd0);
        check("rst s_valid", {28'd0, s_valid}, 32'd0);
        check("rst s_addr", s_addr, 32'd0);
        check("rst s_wdata", s_wdata, 32'd0);
        check("rst s_wstrb", {28'd0, s_wstrb}, 32'd0);
        check("rst err_irq", {31'd0, err_irq}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++)
            apply($sformatf("v%0d", i), v[i]);

        // Timeout, then a late s_ready from the abandoned slave.
        tv = '{32'h0400_0020, 0, 4'h0, 0, 4'b0000, 4'b1000, 1, 32'hDEAD_BEEF, 10, 1};
        apply("late_to", tv);
        for (int c = 0; c < 3; c++) begin
            s_ready = 4'b1000;
            @(posedge clk);
            #1;
            check($sformatf("late ready%0d", c), {31'd0, mem_ready}, 32'd0);
            check($sformatf("late sval%0d", c), {28'd0, s_valid}, 32'd0);
        end
        s_ready = '0;
        tv = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0001_0302, 2, 1};
        apply("late_st", tv);

        // Reset while ACTIVE.
        mem_addr  = 32'h0400_0000;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        @(posedge clk);
        #1;
        check("mid sval", {28'd0, s_valid}, 32'h8);
        @(posedge clk);
        #1;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid rst sval", {28'd0, s_valid}, 32'd0);
        check("mid rst ready", {31'd0, mem_ready}, 32'd0);
        check("mid rst irq", {31'd0, err_irq}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        apply("post_rd", v[0]);
        tv = '{32'h0300_0000, 0, 4'h0, 0, 4'b0000, 4'b0000, 1, 32'h0000_0000, 2, 0};
        apply("post_st", tv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
